// File: rtl/cmp3_sort_sequencer_pkg.sv
// Shared definitions for the block sort sequencer.
//   state_t    : sequencer phase (load block, sort in place, drain block)
//   cnt_width  : width of the compare/swap counters for a block of n words,
//                sized to hold the worst case of (n-1) passes of (n-1) compares
package cmp3_sort_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2((n - 1) * (n - 1) + 1);
  endfunction

endpackage

// File: rtl/cmp3_sort_sequencer_cmp.sv
// Combinational magnitude comparator, the single arithmetic resource of the
// sort sequencer.
//   a, b : WIDTH-bit unsigned operands
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b      (exactly one of gt/eq/lt is high)
module cmp_mag
  import cmp3_sort_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp3_sort_sequencer.sv
// Block bubble sorter built around one shared magnitude comparator.
// A block of N_ENTRIES words is loaded through a valid/ready input stream,
// sorted ascending in place (one compare per cycle, stopping after the first
// pass without a swap), then drained through a valid/ready output stream.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_ready only while loading
//   in_data               : input word
//   out_valid/out_ready   : output handshake, out_valid only while draining
//   out_data, out_last    : sorted word, high with the final word of the block
//   busy                  : sort in progress
//   cmp_count, swap_count : compares/swaps of the last or current sort
module cmp3_sort_sequencer
  import cmp3_sort_sequencer_pkg::*;
#(
  parameter  int WIDTH     = 3,
  parameter  int N_ENTRIES = 4,
  localparam int CNT_W     = cnt_width(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] swap_count
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(N_ENTRIES - 2);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] entry_word [N_ENTRIES];
  logic [IDX_W-1:0] wr_idx_reg, rd_idx_reg, j_reg, pass_reg;
  logic             swap_seen_reg;
  logic [CNT_W-1:0] cmp_count_reg, swap_count_reg;
  logic [WIDTH-1:0] lo_word, hi_word;
  logic             gt, eq, lt, do_swap, sort_done;

  // Operand muxes feeding the single comparator: the adjacent pair at j.
  assign lo_word = entry_word[j_reg];
  assign hi_word = entry_word[j_reg + IDX_W'(1)];

  cmp_mag #(.WIDTH(WIDTH)) u_cmp (
    .a  (lo_word),
    .b  (hi_word),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );

  // eq and lt both keep the current order, which keeps the sort stable.
  assign do_swap = gt & ~(eq | lt);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    sort_done  = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx_reg == IDX_LAST) state_next = ST_SORT;
      end
      ST_SORT: begin
        busy = 1'b1;
        // End of pass: stop if this pass was swap-free or the last pass ran.
        if (j_reg == IDX_PEN &&
            (!(swap_seen_reg || do_swap) || pass_reg == IDX_PEN)) begin
          sort_done  = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_idx_reg == IDX_LAST) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  assign out_data   = (state_reg == ST_DRAIN) ? entry_word[rd_idx_reg] : '0;
  assign out_last   = (state_reg == ST_DRAIN) && (rd_idx_reg == IDX_LAST);
  assign cmp_count  = cmp_count_reg;
  assign swap_count = swap_count_reg;

  // Block storage: each word is either written by the load stream or takes
  // its neighbour's value when the pair at j swaps.
  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      logic [WIDTH-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (state_reg == ST_LOAD && in_valid &&
                     wr_idx_reg == IDX_W'(gi)) begin
          word_reg <= in_data;
        end else if (state_reg == ST_SORT && do_swap) begin
          if (j_reg == IDX_W'(gi))                  word_reg <= hi_word;
          else if (j_reg + IDX_W'(1) == IDX_W'(gi)) word_reg <= lo_word;
        end
      end
      assign entry_word[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      j_reg          <= '0;
      pass_reg       <= '0;
      swap_seen_reg  <= 1'b0;
      cmp_count_reg  <= '0;
      swap_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (in_valid) begin
            if (wr_idx_reg == IDX_LAST) begin
              wr_idx_reg     <= '0;
              j_reg          <= '0;
              pass_reg       <= '0;
              swap_seen_reg  <= 1'b0;
              cmp_count_reg  <= '0;
              swap_count_reg <= '0;
            end else begin
              wr_idx_reg <= wr_idx_reg + IDX_W'(1);
            end
          end
        end
        ST_SORT: begin
          cmp_count_reg <= cmp_count_reg + CNT_W'(1);
          if (do_swap) swap_count_reg <= swap_count_reg + CNT_W'(1);
          if (j_reg == IDX_PEN) begin
            j_reg         <= '0;
            swap_seen_reg <= 1'b0;
            if (!sort_done) pass_reg <= pass_reg + IDX_W'(1);
          end else begin
            j_reg         <= j_reg + IDX_W'(1);
            swap_seen_reg <= swap_seen_reg | do_swap;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_idx_reg == IDX_LAST) begin
              rd_idx_reg <= '0;
              wr_idx_reg <= '0;
            end else begin
              rd_idx_reg <= rd_idx_reg + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp3_sort_sequencer.sv
// Self-checking bench for cmp3_sort_sequencer: directed and random blocks are
// compared against a bubble-sort reference computed on plain arrays.
module tb_cmp3_sort_sequencer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [2:0] in_data, out_data;
  logic [3:0] cmp_count, swap_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp3_sort_sequencer #(.WIDTH(3), .N_ENTRIES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .cmp_count  (cmp_count),
    .swap_count (swap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference: ascending bubble sort, full-length passes, stop after a
  // swap-free pass or after N-1 passes.
  task automatic ref_sort(input int w[N], output int s[N], output int cmps, output int swaps);
    int t;
    bit any;
    s = w;
    cmps = 0;
    swaps = 0;
    for (int p = 0; p < N - 1; p++) begin
      any = 1'b0;
      for (int k = 0; k < N - 1; k++) begin
        cmps++;
        if (s[k] > s[k+1]) begin
          t = s[k]; s[k] = s[k+1]; s[k+1] = t;
          swaps++;
          any = 1'b1;
        end
      end
      if (!any) break;
    end
  endtask

  // Returns just after the edge that accepts the N-th word.
  task automatic load_block(input int w[N]);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 3'(w[i]);
      check("in_ready_load", in_ready, 1);
      @(posedge clk);
    end
  endtask

  // stall_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  task automatic finish_block(input int w[N], input bit hold_valid, input int stall_mode);
    int s[N];
    int cmps, swaps, n, k, cyc;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ref_sort(w, s, cmps, swaps);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      in_valid  = hold_valid;
      in_data   = 3'($urandom);
      out_ready = 1'b1;
      if (out_valid) break;
      check("busy_sort", busy, 1);
      check("in_ready_sort", in_ready, 0);
    end
    check("out_valid_reached", out_valid, 1);
    check("latency", n, cmps + 1);
    check("cmp_count", cmp_count, cmps);
    check("swap_count", swap_count, swaps);
    k = 0;
    cyc = 0;
    while (k < N && cyc < 40) begin
      if (stall_mode == 0)      out_ready = 1'b1;
      else if (stall_mode == 1) out_ready = pat[cyc % 4];
      else                      out_ready = 1'($urandom_range(0, 1));
      if (hold_valid) in_data = 3'($urandom);
      check("out_valid_drain", out_valid, 1);
      check("in_ready_drain", in_ready, 0);
      check("busy_drain", busy, 0);
      check("out_data", out_data, s[k]);
      check("out_last", out_last, (k == N - 1));
      $display("drain word %0d data=%0d last=%0b ready=%0b", k, out_data, out_last, out_ready);
      if (out_ready) k++;
      cyc++;
      if (k < N) @(negedge clk);
    end
    check("drain_words", k, N);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("cmp_hold", cmp_count, cmps);
    check("swap_hold", swap_count, swaps);
    $display("block %0d %0d %0d %0d: cmps=%0d swaps=%0d", w[0], w[1], w[2], w[3], cmps, swaps);
  endtask

  task automatic run_block(input int w[N], input bit hold_valid, input int stall_mode);
    load_block(w);
    finish_block(w, hold_valid, stall_mode);
  endtask

  initial begin
    int blk[N];
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cmp", cmp_count, 0);
    check("rst_swap", swap_count, 0);
    rst = 1'b0;

    blk = '{5, 3, 7, 1}; run_block(blk, 1'b0, 0);
    blk = '{0, 2, 4, 6}; run_block(blk, 1'b0, 0);
    blk = '{7, 6, 5, 4}; run_block(blk, 1'b0, 0);
    blk = '{6, 6, 6, 6}; run_block(blk, 1'b0, 0);
    blk = '{4, 1, 6, 2}; run_block(blk, 1'b1, 0);
    blk = '{3, 0, 5, 3}; run_block(blk, 1'b0, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) blk[i] = $urandom_range(0, 7);
      run_block(blk, r[0], 2);
    end

    // Reset during the second SORT cycle discards the block.
    blk = '{3, 2, 1, 0};
    load_block(blk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_sort1", busy, 1);
    @(negedge clk);
    check("busy_sort2", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cmp", cmp_count, 0);
    check("mid_rst_swap", swap_count, 0);
    check("mid_rst_out_data", out_data, 0);
    blk = '{2, 1, 0, 3}; run_block(blk, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
